// File: rtl/fft_bfly_exec_unit.sv
// Radix-2 butterfly execution unit for the in-place 1024-point FFT.
// It reads ping-pong data RAM and twiddle ROM, computes the scaled butterfly, and writes to the opposite bank.
module fft_bfly_exec_unit #(
  parameter int DW  = 16,
  parameter int TW  = 16,
  parameter int AW  = 10,
  parameter int TAW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AW-1:0]     addr_a_i,
  input  logic [AW-1:0]     addr_b_i,
  input  logic [TAW-1:0]    tw_addr_i,
  input  logic              memsel_i,
  input  logic              last_i,
  output logic              rd_en_o,
  output logic              rd_bank_o,
  output logic [AW-1:0]     rd_addr_a_o,
  output logic [AW-1:0]     rd_addr_b_o,
  input  logic [2*DW-1:0]   rd_data_a_i,
  input  logic [2*DW-1:0]   rd_data_b_i,
  output logic [TAW-1:0]    tw_addr_o,
  input  logic [2*TW-1:0]   tw_data_i,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [AW-1:0]     wr_addr_a_o,
  output logic [AW-1:0]     wr_addr_b_o,
  output logic [2*DW-1:0]   wr_data_a_o,
  output logic [2*DW-1:0]   wr_data_b_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PW = DW + TW + 1;

  logic              accept;
  logic              in_flight;
  logic              held_sel;
  logic              hist;

  logic              s1_valid;
  logic              s1_bank;
  logic              s1_last;
  logic [AW-1:0]     s1_addr_a;
  logic [AW-1:0]     s1_addr_b;

  logic              s2_valid;
  logic              s2_bank;
  logic              s2_last;
  logic [AW-1:0]     s2_addr_a;
  logic [AW-1:0]     s2_addr_b;
  logic signed [DW-1:0] s2_ar;
  logic signed [DW-1:0] s2_ai;
  logic signed [DW:0]   s2_pr;
  logic signed [DW:0]   s2_pi;

  logic              s3_last;

  logic signed [DW-1:0]    br;
  logic signed [DW-1:0]    bi;
  logic signed [TW-1:0]    wr;
  logic signed [TW-1:0]    wi;
  logic signed [DW+TW-1:0] m_rr;
  logic signed [DW+TW-1:0] m_ii;
  logic signed [DW+TW-1:0] m_ri;
  logic signed [DW+TW-1:0] m_ir;
  logic signed [PW-1:0]    pr_full;
  logic signed [PW-1:0]    pi_full;
  logic signed [PW-1:0]    pr_shift;
  logic signed [PW-1:0]    pi_shift;

  logic signed [DW+1:0] a_ext_r;
  logic signed [DW+1:0] a_ext_i;
  logic signed [DW+1:0] p_ext_r;
  logic signed [DW+1:0] p_ext_i;
  logic signed [DW+1:0] sum_r;
  logic signed [DW+1:0] sum_i;
  logic signed [DW+1:0] dif_r;
  logic signed [DW+1:0] dif_i;

  // Clamp the scaled product into DW+1 bits when the discarded high bits are not pure sign extension.
  function automatic logic signed [DW:0] sat_prod(input logic signed [PW-1:0] x);
    if ((&x[PW-1:DW]) || !(|x[PW-1:DW]))
      sat_prod = x[DW:0];
    else if (x[PW-1])
      sat_prod = {1'b1, {DW{1'b0}}};
    else
      sat_prod = {1'b0, {DW{1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] sat_out(input logic signed [DW+1:0] x);
    if ((&x[DW+1:DW-1]) || !(|x[DW+1:DW-1]))
      sat_out = x[DW-1:0];
    else if (x[DW+1])
      sat_out = {1'b1, {(DW-1){1'b0}}};
    else
      sat_out = {1'b0, {(DW-1){1'b1}}};
  endfunction

  // A bank switch waits until every older-bank butterfly has left the pipeline, so reads never overtake writes.
  assign in_flight   = s1_valid | s2_valid | wr_en_o;
  assign ready_o     = ~(valid_i & hist & (memsel_i ^ held_sel) & in_flight);
  assign accept      = valid_i & ready_o;
  assign rd_en_o     = accept;
  assign rd_bank_o   = memsel_i;
  assign rd_addr_a_o = addr_a_i;
  assign rd_addr_b_o = addr_b_i;
  assign tw_addr_o   = tw_addr_i;
  assign busy_o      = in_flight;

  assign br = rd_data_b_i[2*DW-1:DW];
  assign bi = rd_data_b_i[DW-1:0];
  assign wr = tw_data_i[2*TW-1:TW];
  assign wi = tw_data_i[TW-1:0];

  assign m_rr = br * wr;
  assign m_ii = bi * wi;
  assign m_ri = br * wi;
  assign m_ir = bi * wr;

  assign pr_full  = {m_rr[DW+TW-1], m_rr} - {m_ii[DW+TW-1], m_ii};
  assign pi_full  = {m_ri[DW+TW-1], m_ri} + {m_ir[DW+TW-1], m_ir};
  assign pr_shift = pr_full >>> (TW - 1);
  assign pi_shift = pi_full >>> (TW - 1);

  assign a_ext_r = {{2{s2_ar[DW-1]}}, s2_ar};
  assign a_ext_i = {{2{s2_ai[DW-1]}}, s2_ai};
  assign p_ext_r = {s2_pr[DW], s2_pr};
  assign p_ext_i = {s2_pi[DW], s2_pi};
  assign sum_r   = a_ext_r + p_ext_r;
  assign sum_i   = a_ext_i + p_ext_i;
  assign dif_r   = a_ext_r - p_ext_r;
  assign dif_i   = a_ext_i - p_ext_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_sel <= 1'b0;
      hist     <= 1'b0;
    end else if (accept) begin
      held_sel <= memsel_i;
      hist     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bank   <= 1'b0;
      s1_last   <= 1'b0;
      s1_addr_a <= '0;
      s1_addr_b <= '0;
    end else begin
      s1_valid  <= accept;
      s1_bank   <= memsel_i;
      s1_last   <= last_i;
      s1_addr_a <= addr_a_i;
      s1_addr_b <= addr_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_bank   <= 1'b0;
      s2_last   <= 1'b0;
      s2_addr_a <= '0;
      s2_addr_b <= '0;
      s2_ar     <= '0;
      s2_ai     <= '0;
      s2_pr     <= '0;
      s2_pi     <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_bank   <= s1_bank;
      s2_last   <= s1_last;
      s2_addr_a <= s1_addr_a;
      s2_addr_b <= s1_addr_b;
      s2_ar     <= rd_data_a_i[2*DW-1:DW];
      s2_ai     <= rd_data_a_i[DW-1:0];
      s2_pr     <= sat_prod(pr_shift);
      s2_pi     <= sat_prod(pi_shift);
    end
  end

  // Results land in the bank opposite to the one the operands came from.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_o     <= 1'b0;
      wr_bank_o   <= 1'b0;
      wr_addr_a_o <= '0;
      wr_addr_b_o <= '0;
      wr_data_a_o <= '0;
      wr_data_b_o <= '0;
      s3_last     <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      wr_en_o     <= s2_valid;
      wr_bank_o   <= ~s2_bank;
      wr_addr_a_o <= s2_addr_a;
      wr_addr_b_o <= s2_addr_b;
      wr_data_a_o <= {sat_out(sum_r >>> 1), sat_out(sum_i >>> 1)};
      wr_data_b_o <= {sat_out(dif_r >>> 1), sat_out(dif_i >>> 1)};
      s3_last     <= s2_valid & s2_last;
      done_o      <= wr_en_o & s3_last;
    end
  end

endmodule

// File: tb/tb_fft_bfly_exec_unit.sv
// Self-checking bench for fft_bfly_exec_unit: directed test-plan cases plus randomized descriptors
// checked cycle by cycle against a behavioural butterfly/interlock model.
module tb_fft_bfly_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [9:0]  addr_a_i;
  logic [9:0]  addr_b_i;
  logic [8:0]  tw_addr_i;
  logic        memsel_i;
  logic        last_i;
  logic        rd_en_o;
  logic        rd_bank_o;
  logic [9:0]  rd_addr_a_o;
  logic [9:0]  rd_addr_b_o;
  logic [31:0] rd_data_a_i;
  logic [31:0] rd_data_b_i;
  logic [8:0]  tw_addr_o;
  logic [31:0] tw_data_i;
  logic        wr_en_o;
  logic        wr_bank_o;
  logic [9:0]  wr_addr_a_o;
  logic [9:0]  wr_addr_b_o;
  logic [31:0] wr_data_a_o;
  logic [31:0] wr_data_b_o;
  logic        busy_o;
  logic        done_o;

  fft_bfly_exec_unit #(.DW(16), .TW(16), .AW(10), .TAW(9)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .tw_addr_i(tw_addr_i),
    .memsel_i(memsel_i), .last_i(last_i),
    .rd_en_o(rd_en_o), .rd_bank_o(rd_bank_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
    .tw_addr_o(tw_addr_o), .tw_data_i(tw_data_i),
    .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
    .wr_data_a_o(wr_data_a_o), .wr_data_b_o(wr_data_b_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [2][1024];
  logic [31:0] rom [512];

  // Registered-read memories; contents stay fixed, the bench only checks what is written.
  always @(posedge clk) begin
    rd_data_a_i <= mem[rd_bank_o][rd_addr_a_o];
    rd_data_b_i <= mem[rd_bank_o][rd_addr_b_o];
    tw_data_i   <= rom[tw_addr_o];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference butterfly in plain integer arithmetic.
  function automatic void refBfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                                  output logic [31:0] oa, output logic [31:0] ob);
    longint ar, ai, br, bi, wr, wi, pr, pi, xar, xai, xbr, xbi;
    ar = $signed(a[31:16]); ai = $signed(a[15:0]);
    br = $signed(b[31:16]); bi = $signed(b[15:0]);
    wr = $signed(w[31:16]); wi = $signed(w[15:0]);
    pr = clamp((br * wr - bi * wi) >>> 15, -65536, 65535);
    pi = clamp((br * wi + bi * wr) >>> 15, -65536, 65535);
    xar = clamp((ar + pr) >>> 1, -32768, 32767);
    xai = clamp((ai + pi) >>> 1, -32768, 32767);
    xbr = clamp((ar - pr) >>> 1, -32768, 32767);
    xbi = clamp((ai - pi) >>> 1, -32768, 32767);
    oa = {xar[15:0], xai[15:0]};
    ob = {xbr[15:0], xbi[15:0]};
  endfunction

  typedef struct {
    int          due;
    logic        bank;
    logic [9:0]  aa;
    logic [9:0]  ab;
    logic [31:0] da;
    logic [31:0] db;
  } wr_exp_t;

  wr_exp_t wq[$];
  int      dq[$];
  int      cyc;
  int      last_acc;
  logic    started;
  logic    hist_m;
  logic    held_m;
  logic    exp_ready;
  logic    exp_acc;
  logic    exp_done;
  wr_exp_t e;

  initial begin
    cyc = 0; last_acc = -100; started = 1'b0; hist_m = 1'b0; held_m = 1'b0;
  end

  // Cycle monitor: a descriptor accepted just after negedge N must be written at N+3 and
  // signal done at N+4; a bank change stalls while anything accepted in the last 3 cycles remains.
  always @(negedge clk) begin
    cyc++;
    exp_ready = !(valid_i && hist_m && (memsel_i != held_m) && (cyc - last_acc <= 3));
    exp_acc   = rst_n && valid_i && exp_ready;
    if (started) begin
      checkOutput("ready", ready_o, exp_ready);
      checkOutput("rd_en", rd_en_o, valid_i && exp_ready);
      checkOutput("busy", busy_o, (cyc - last_acc <= 3));
      if (wq.size() > 0 && wq[0].due == cyc) begin
        e = wq.pop_front();
        checkOutput("wr_en", wr_en_o, 1);
        checkOutput("wr_bank", wr_bank_o, e.bank);
        checkOutput("wr_addr_a", wr_addr_a_o, e.aa);
        checkOutput("wr_addr_b", wr_addr_b_o, e.ab);
        checkOutput("wr_data_a", wr_data_a_o, e.da);
        checkOutput("wr_data_b", wr_data_b_o, e.db);
      end else begin
        checkOutput("wr_en_idle", wr_en_o, 0);
      end
      exp_done = (dq.size() > 0 && dq[0] == cyc);
      if (exp_done) void'(dq.pop_front());
      checkOutput("done", done_o, exp_done);
      if (exp_acc) begin
        checkOutput("rd_addr_a", rd_addr_a_o, addr_a_i);
        checkOutput("rd_addr_b", rd_addr_b_o, addr_b_i);
        checkOutput("tw_addr", tw_addr_o, tw_addr_i);
        checkOutput("rd_bank", rd_bank_o, memsel_i);
      end
    end
    if (!rst_n) begin
      wq.delete(); dq.delete();
      hist_m = 1'b0; held_m = 1'b0; last_acc = -100; started = 1'b1;
    end else if (exp_acc) begin
      e.due  = cyc + 3;
      e.bank = ~memsel_i;
      e.aa   = addr_a_i;
      e.ab   = addr_b_i;
      refBfly(mem[memsel_i][addr_a_i], mem[memsel_i][addr_b_i], rom[tw_addr_i], e.da, e.db);
      wq.push_back(e);
      if (last_i) dq.push_back(cyc + 4);
      hist_m = 1'b1; held_m = memsel_i; last_acc = cyc;
    end
  end

  // Present one descriptor and hold it until accepted; returns the number of stalled cycles.
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic [8:0] tw,
                               input logic sel, input logic last, output int stalls);
    logic acc;
    valid_i = 1'b1; addr_a_i = a; addr_b_i = b; tw_addr_i = tw; memsel_i = sel; last_i = last;
    stalls = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk); #1;
      if (acc) return;
      stalls++;
    end
    checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic checkDirected(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b,
                               input logic last);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_wr_en"}, wr_en_o, 1);
    checkOutput({tag, "_wr_bank"}, wr_bank_o, 1);
    checkOutput({tag, "_data_a"}, wr_data_a_o, exp_a);
    checkOutput({tag, "_data_b"}, wr_data_b_o, exp_b);
    checkOutput({tag, "_busy_t3"}, busy_o, 1);
    @(negedge clk);
    checkOutput({tag, "_done_t4"}, done_o, last);
    checkOutput({tag, "_busy_t4"}, busy_o, 0);
    @(negedge clk);
    checkOutput({tag, "_done_t5"}, done_o, 0);
    @(posedge clk); #1;
  endtask

  int          st;
  logic        pend;
  logic        acc_r;
  logic [31:0] r;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; addr_a_i = '0; addr_b_i = '0; tw_addr_i = '0;
    memsel_i = 1'b0; last_i = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      for (int bk = 0; bk < 2; bk++) begin
        if (i % 16 == 0)      mem[bk][i] = 32'h8000_8000;
        else if (i % 16 == 1) mem[bk][i] = 32'h7FFF_7FFF;
        else                  mem[bk][i] = $urandom;
      end
    end
    for (int i = 0; i < 512; i++) rom[i] = (i % 16 == 0) ? 32'h8000_8000 : $urandom;
    mem[0][10] = 32'h03E8_0000;
    mem[0][20] = 32'h00C8_0000;
    mem[0][30] = 32'h7FFF_0000;
    mem[0][31] = 32'h8000_0000;
    rom[3]     = 32'h7FFF_0000;
    rom[4]     = 32'h0000_8000;
    rom[5]     = 32'h8000_0000;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_wr_en", wr_en_o, 0);
    checkOutput("reset_ready", ready_o, 1);
    @(posedge clk); #1;

    applyStimulus(10'd10, 10'd20, 9'd3, 1'b0, 1'b0, st);
    valid_i = 1'b0;
    checkDirected("unity_tw", 32'h0257_0000, 32'h0190_0000, 1'b0);

    applyStimulus(10'd10, 10'd20, 9'd4, 1'b0, 1'b0, st);
    valid_i = 1'b0;
    checkDirected("minus_j_tw", 32'h01F4_FF9C, 32'h01F4_0064, 1'b0);

    applyStimulus(10'd30, 10'd31, 9'd5, 1'b0, 1'b1, st);
    valid_i = 1'b0;
    checkDirected("sat_last", 32'h7FFF_0000, 32'hFFFF_0000, 1'b1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(10'(100 + 2 * i), 10'(101 + 2 * i), 9'(i), 1'b0, 1'b0, st);
      checkOutput("same_bank_stall", st, 0);
    end
    applyStimulus(10'd200, 10'd201, 9'd7, 1'b1, 1'b0, st);
    checkOutput("bank_switch_stall", st, 3);
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    applyStimulus(10'd300, 10'd301, 9'd8, 1'b1, 1'b0, st);
    applyStimulus(10'd302, 10'd303, 9'd9, 1'b1, 1'b1, st);
    valid_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_reset_wr_en", wr_en_o, 0);
      checkOutput("post_reset_done", done_o, 0);
      checkOutput("post_reset_busy", busy_o, 0);
      checkOutput("post_reset_ready", ready_o, 1);
    end
    @(posedge clk); #1;

    pend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!pend) begin
        r = $urandom;
        valid_i   = ($urandom_range(0, 9) < 7);
        addr_a_i  = r[9:0];
        addr_b_i  = r[19:10];
        tw_addr_i = r[28:20];
        if ($urandom_range(0, 9) == 0) memsel_i = ~memsel_i;
        last_i    = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      acc_r = valid_i && ready_o;
      @(posedge clk); #1;
      pend = valid_i && !acc_r;
    end
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_writes", wq.size(), 0);
    checkOutput("drain_done", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_bfly_exec_unit.md
Name: fft_bfly_exec_unit

Overview:
- Executes the butterfly operations of the 1024-point in-place radix-2 FFT. It consumes the per-cycle butterfly descriptors issued by the address generator: operand addresses A/B, twiddle address and bank select.
- Reads both operands from the ping-pong data RAM bank selected by memsel and the twiddle from the twiddle ROM, then computes the scaled radix-2 butterfly.
- Writes both results to the opposite bank at the same addresses.
- Throttles the generator with ready_o across bank switches so no read-after-write hazard occurs between stages.

Parameters:
- DW, 16, signed width of each real/imag data component (RAM word = 2*DW, real in upper half).
- TW, 16, signed width of each twiddle component, Q1.(TW-1) format (ROM word = 2*TW, real in upper half).
- AW, 10, data RAM address width.
- TAW, 9, twiddle ROM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  butterfly descriptor valid
- ready_o  out  1  descriptor accepted when valid_i && ready_o
- addr_a_i  in  AW  operand A address
- addr_b_i  in  AW  operand B address
- tw_addr_i  in  TAW  twiddle ROM address
- memsel_i  in  1  read bank; write bank is ~memsel_i
- last_i  in  1  marks final butterfly of the transform
- rd_en_o  out  1  data RAM read strobe
- rd_bank_o  out  1  bank being read
- rd_addr_a_o  out  AW  read address, port A
- rd_addr_b_o  out  AW  read address, port B
- rd_data_a_i  in  2*DW  RAM read data, port A, 1-cycle latency
- rd_data_b_i  in  2*DW  RAM read data, port B, 1-cycle latency
- tw_addr_o  out  TAW  twiddle ROM address
- tw_data_i  in  2*TW  twiddle data, 1-cycle latency
- wr_en_o  out  1  data RAM write strobe, both ports
- wr_bank_o  out  1  bank being written
- wr_addr_a_o  out  AW  write address, port A
- wr_addr_b_o  out  AW  write address, port B
- wr_data_a_o  out  2*DW  write data, port A
- wr_data_b_o  out  2*DW  write data, port B
- busy_o  out  1  at least one butterfly in flight
- done_o  out  1  one-cycle pulse, transform complete

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all pipeline valid bits, the bank-history flag and all registered outputs to 0. In-flight butterflies are discarded with no writes. done_o=0, busy_o=0. ready_o=1 after reset.
- S0, cycle T (accept):
  - rd_en_o = valid_i && ready_o, combinational.
  - rd_addr_a/b_o, tw_addr_o and rd_bank_o pass through combinationally from the inputs.
  - addr_a/b, memsel and last enter pipeline stage 1.
- S1, cycle T+1: RAM/ROM data valid. Complex product P = B*W:
  - Pr = Br*Wr - Bi*Wi.
  - Pi = Br*Wi + Bi*Wr.
  - Full precision, arithmetic shift right by TW-1 (floor), saturated to DW+1 bits.
  - A and P registered at the end of T+1.
- S2, cycle T+2:
  - A' = (A+P)>>>1 and B' = (A-P)>>>1 per component, in DW+2 bits, floor, saturated to DW bits.
  - Registered at the end of T+2.
- S3, cycle T+3: wr_en_o=1. wr_bank_o = ~memsel of that butterfly. wr_addr_a/b_o are the original A/B addresses. wr_data_a_o=A', wr_data_b_o=B'. Fixed latency 3 from accept to write. Sustained throughput 1 butterfly/cycle.
- Bank-switch interlock:
  - A register holds the memsel of the last accepted butterfly, plus a history flag.
  - ready_o=0 while valid_i=1, the history flag is set, memsel_i differs from the held memsel, and any stage S1..S3 is valid.
  - Result: earliest next-bank accept is T+4 after the last old-bank accept at T, i.e. 3 bubbles.
  - A first-ever accept or a same-bank accept is never stalled.
- While ready_o=0 the upstream holds all descriptor inputs stable. rd_en_o stays 0 during the stall.
- busy_o = OR of valid bits S1..S3.
- done_o pulses in cycle T+4 for the butterfly accepted at T with last_i=1. This holds even if a new transform is accepted in the same cycle.
- Simultaneous write (S3) and read (S0) to the same bank cannot occur due to the interlock. Same-bank pipelined reads/writes never collide, because reads use memsel and writes use ~memsel.
- No internal addressing state. Address wrap and stage counting are owned by the generator.

Test Plan:
- W=(0x7FFF,0), A=(1000,0), B=(200,0), accept at T -> wr_en_o=1 at T+3, A'=(599,0), B'=(400,0), wr_bank_o=~memsel_i.
- W=(0,0x8000) (= -j), A=(1000,0), B=(200,0) -> A'=(500,-100), B'=(500,100).
- W=(0x8000,0), A=(32767,0), B=(-32768,0) -> P=(32768,0) held in DW+1 bits, A'=(32767,0), B'=(-1,0); no overflow wrap.
- 8 back-to-back descriptors with memsel=0, then memsel=1 presented immediately -> ready_o low for exactly 3 cycles, first memsel=1 rd_en_o 4 cycles after last memsel=0 accept, all 8 writes to bank 1.
- Last descriptor with last_i=1 accepted at T -> done_o single pulse at T+4, busy_o falls at T+4.
- rst_n=0 asserted at T+2 with 2 butterflies in flight -> no wr_en_o afterwards, done_o=0, busy_o=0, ready_o=1 once rst_n=1.
